pxs_vga_timing_gen: RTL

- Head-of-chain source stage of the iPxs pixel-stream pipeline.
- Generates 640x480@60 progressive VGA timing and emits the 23-bit VGA stream (sync, coordinates, ActiveVideo; no RGB).
- Downstream colour stages consume this stream and append the 3-bit RGB field.
- Also provides frame/line start strobes for stages that need frame-synchronous state.

---
 rtl/pxs_pkg.sv | 41 ++++
 rtl/pxs_timing_counter.sv | 28 ++
 rtl/pxs_vga_timing_gen.sv | 102 ++++++++++
 3 files changed

// File: rtl/pxs_pkg.sv
// rtl/pxs_pkg.sv - shared iPxs stream field map, widths and default VGA timing
package pxs_pkg;

  localparam int VGA_STR_W = 23;
  localparam int RGB_STR_W = 26;
  localparam int CNT_W     = 10;

  localparam int ACTIVEVIDEO = 0;
  localparam int VSYNC       = 1;
  localparam int HSYNC       = 2;
  localparam int YCOORD_LSB  = 3;
  localparam int YCOORD_MSB  = 12;
  localparam int XCOORD_LSB  = 13;
  localparam int XCOORD_MSB  = 22;
  localparam int RGB_LSB     = 23;
  localparam int RGB_MSB     = 25;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Field order mirrors the bit map: X in the top bits, ActiveVideo at bit 0.
  typedef struct packed {
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             hsync;
    logic             vsync;
    logic             active;
  } vga_str_t;

  // Compared as int so a window ending exactly at 1024 does not truncate.
  function automatic logic in_window(input logic [CNT_W-1:0] cnt, input int lo, input int len);
    return (int'(cnt) >= lo) && (int'(cnt) < lo + len);
  endfunction

endpackage

// File: rtl/pxs_timing_counter.sv
// rtl/pxs_timing_counter.sv - wrap counter 0..TOTAL-1 with enable and terminal count
module pxs_timing_counter #(
  parameter int W     = 10,
  parameter int TOTAL = 800
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LAST);

endmodule

// File: rtl/pxs_vga_timing_gen.sv
// rtl/pxs_vga_timing_gen.sv - 640x480@60 VGA timing source; PXS_FRAME_COUNT_EN adds frame_cnt_o
module pxs_vga_timing_gen
  import pxs_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                 px_clk,
  input  logic                 reset,
  input  logic                 px_en,
  output logic [VGA_STR_W-1:0] VGAStr_o,
  output logic                 line_start_o,
  output logic                 frame_start_o
`ifdef PXS_FRAME_COUNT_EN
  ,
  output logic [7:0]           frame_cnt_o
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [CNT_W-1:0] w_hcnt;
  logic [CNT_W-1:0] w_vcnt;
  logic             w_h_tc;
  logic             w_v_tc;
  logic             w_line_first;
  logic             w_frame_first;
  vga_str_t         r_str;
  logic             r_line_start;
  logic             r_frame_start;

  pxs_timing_counter #(.W(CNT_W), .TOTAL(H_TOTAL)) u_hcnt (
    .i_clk   (px_clk),
    .i_reset (reset),
    .i_en    (px_en),
    .o_cnt   (w_hcnt),
    .o_tc    (w_h_tc)
  );

  // Vertical advances only on the enabled cycle that closes a line.
  pxs_timing_counter #(.W(CNT_W), .TOTAL(V_TOTAL)) u_vcnt (
    .i_clk   (px_clk),
    .i_reset (reset),
    .i_en    (px_en & w_h_tc),
    .o_cnt   (w_vcnt),
    .o_tc    (w_v_tc)
  );

  assign w_line_first  = (w_hcnt == '0);
  assign w_frame_first = w_line_first && (w_vcnt == '0) && !(w_h_tc && w_v_tc);

  always_ff @(posedge px_clk) begin
    if (reset) begin
      r_str.x       <= '0;
      r_str.y       <= '0;
      r_str.hsync   <= ~SYNC_POL;
      r_str.vsync   <= ~SYNC_POL;
      r_str.active  <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (px_en) begin
      r_str.x       <= w_hcnt;
      r_str.y       <= w_vcnt;
      r_str.hsync   <= in_window(w_hcnt, H_ACTIVE + H_FP, H_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_str.vsync   <= in_window(w_vcnt, V_ACTIVE + V_FP, V_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_str.active  <= in_window(w_hcnt, 0, H_ACTIVE) && in_window(w_vcnt, 0, V_ACTIVE);
      r_line_start  <= w_line_first;
      r_frame_start <= w_frame_first;
    end else begin
      // Held pixel: keep the stream, but never stretch a strobe.
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

`ifdef PXS_FRAME_COUNT_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge px_clk) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (px_en && w_frame_first) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign frame_cnt_o = r_frame_cnt;
`endif

  assign VGAStr_o      = r_str;
  assign line_start_o  = r_line_start;
  assign frame_start_o = r_frame_start;

endmodule
